// File: rtl/bcd2bin.sv
// Sequential 4-digit packed-BCD to 14-bit binary converter (reverse double-dabble).
// Optional invalid-digit check is compiled in with `define BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] bcd_d_in,
  output logic [13:0] bin_d_out,
  output logic        rdy,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;
  localparam int unsigned BCD_W  = DIGITS * 4;
  localparam int unsigned WORK_W = BCD_W + BIN_W;

  localparam logic [3:0] LAST_ITER = 4'd13;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // After a right shift a digit of 8+ means a 1 crossed in from the digit above;
  // subtracting 3 turns that weight-8 bit back into a decimal 5.
  function automatic logic [BCD_W-1:0] adjust_bcd(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i+3]) r[4*i +: 4] = b[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

`ifdef BCD2BIN_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  logic [1:0]        state_q, state_d;
  logic [WORK_W-1:0] work_q,  work_d;
  logic [3:0]        iter_q,  iter_d;
  logic [BIN_W-1:0]  bin_q,   bin_d;
  logic              rdy_q,   rdy_d;
  logic              busy_q,  busy_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic              bad_q,   bad_d;
  logic              err_q,   err_d;
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    rdy_d   = 1'b0;
    busy_d  = 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    bad_d   = bad_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // busy stays up through the rdy cycle and only drops when idle with no new request
        busy_d = en;
        if (en) begin
          work_d  = {bcd_d_in, {BIN_W{1'b0}}};
          iter_d  = 4'd0;
          state_d = ST_SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          bad_d = has_bad_digit(bcd_d_in);
          if (bad_d) state_d = ST_DONE;
`endif
        end
      end
      ST_SHIFT: begin
        work_d  = work_q >> 1;
        state_d = ST_ADJUST;
      end
      ST_ADJUST: begin
        work_d[WORK_W-1 -: BCD_W] = adjust_bcd(work_q[WORK_W-1 -: BCD_W]);
        iter_d  = iter_q + 4'd1;
        state_d = (iter_q == LAST_ITER) ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        bin_d   = work_q[BIN_W-1:0];
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (bad_q) bin_d = '0;
        err_d = bad_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      iter_q  <= '0;
      bin_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      iter_q  <= iter_d;
      bin_q   <= bin_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      bad_q   <= bad_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bin_d_out = bin_q;
  assign rdy       = rdy_q;
  assign busy      = busy_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// Directed self-checking bench for bcd2bin: latency, boundaries, back-to-back,
// ignored requests, mid-conversion reset and (if enabled) the digit check.
module tb_bcd2bin;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] bcd_in;
  logic [13:0] bin_out;
  logic        rdy;
  logic        busy;
  logic        err;

  int total;
  int bad;

  bcd2bin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bcd_d_in  (bcd_in),
    .bin_d_out (bin_out),
    .rdy       (rdy),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request; expects rdy want_lat edges after accept, busy high want_lat+1 cycles.
  task automatic conv(input string tag, input logic [15:0] v, input logic [13:0] want,
                      input int want_lat, input logic want_err);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bcd_in = v;
    en     = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!rdy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, lat, want_lat);
    check({tag, " rdy"}, {31'd0, rdy}, 32'd1);
    check({tag, " bin"}, {18'd0, bin_out}, {18'd0, want});
    check({tag, " err"}, {31'd0, err}, {31'd0, want_err});
    check({tag, " busy_cycles"}, busy_cnt, want_lat + 1);
    @(posedge clk);
    #1;
    check({tag, " rdy_clear"}, {31'd0, rdy}, 32'd0);
    check({tag, " busy_clear"}, {31'd0, busy}, 32'd0);
    check({tag, " bin_hold"}, {18'd0, bin_out}, {18'd0, want});
  endtask

  initial begin
    int lat;
    int first;
    int pulses;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    bcd_in = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("reset bin", {18'd0, bin_out}, 32'd0);
    check("reset rdy", {31'd0, rdy}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    conv("c1234", 16'h1234, 14'd1234, 29, 1'b0);
    conv("c0000", 16'h0000, 14'd0, 29, 1'b0);
    conv("c9999", 16'h9999, 14'd9999, 29, 1'b0);
    conv("c0009", 16'h0009, 14'd9, 29, 1'b0);
    conv("c1000", 16'h1000, 14'd1000, 29, 1'b0);

    // en held high: second request accepted in the rdy cycle of the first
    @(negedge clk);
    bcd_in = 16'h0042;
    en     = 1'b1;
    @(posedge clk);
    #1 bcd_in = 16'h0777;
    lat = 0;
    while (!rdy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b first latency", lat, 29);
    check("b2b first bin", {18'd0, bin_out}, 32'd42);
    check("b2b busy in rdy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 en = 1'b0;
    check("b2b busy after accept", {31'd0, busy}, 32'd1);
    check("b2b rdy pulse", {31'd0, rdy}, 32'd0);
    lat = 1;
    while (!rdy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b spacing", lat, 30);
    check("b2b second bin", {18'd0, bin_out}, 32'd777);
    repeat (2) @(posedge clk);
    #1;
    check("b2b idle", {31'd0, busy}, 32'd0);

    // en pulse mid-conversion must be ignored
    @(negedge clk);
    bcd_in = 16'h0001;
    en     = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 10) begin
        bcd_in = 16'h5555;
        en     = 1'b1;
      end
      @(posedge clk);
      #1;
      if (k == 10) en = 1'b0;
      if (rdy) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("ign first rdy", first, 29);
    check("ign rdy count", pulses, 1);
    check("ign bin", {18'd0, bin_out}, 32'd1);
    check("ign busy", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-conversion
    @(negedge clk);
    bcd_in = 16'h8765;
    en     = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst bin", {18'd0, bin_out}, 32'd0);
    check("arst rdy", {31'd0, rdy}, 32'd0);
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv("c0100", 16'h0100, 14'd100, 29, 1'b0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    conv("bad12A4", 16'h12A4, 14'd0, 1, 1'b1);
    conv("c0321", 16'h0321, 14'd321, 29, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
